uc_rr_sched: RTL and testbench

Round-robin scheduler that shares the single unit-clause (UC) arbiter input port among `NUM_ENGINE` BCP engines. Each engine presents at most one pending signed UC literal; the scheduler grants one engine per cycle, registers the literal, and forwards it to the arbiter over a valid/ready handshake. A conflict from the arbiter halts all scheduling until software/top-level issues a flush.

---
 rtl/uc_rr_sched.sv | 139 +++++++++++++
 tb/tb_uc_rr_sched.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uc_rr_sched.sv
// Round-robin scheduler feeding one unit-clause arbiter port from NUM_ENGINE BCP engines.
// Optional duplicate-literal filter enabled by defining UC_SCHED_DEDUP_EN.
module uc_rr_sched #(
  parameter  int NUM_ENGINE = 4,
  parameter  int LIT_W      = 10,
  localparam int SRC_W      = $clog2(NUM_ENGINE)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_ENGINE-1:0]               eng_req,
  input  logic [NUM_ENGINE-1:0][LIT_W-1:0]    eng_lit,
  output logic [NUM_ENGINE-1:0]               eng_gnt,
  output logic                                out_valid,
  output logic [LIT_W-1:0]                    out_lit,
  output logic [SRC_W-1:0]                    out_src,
  input  logic                                out_ready,
  input  logic                                conflict_in,
  input  logic                                flush,
  output logic                                busy,
  output logic                                halted
);

  typedef enum logic [1:0] {IDLE, HOLD, HALT} state_t;

  state_t           state, state_next;
  logic [SRC_W-1:0] ptr, ptr_next;
  logic [SRC_W-1:0] winner;
  logic [LIT_W-1:0] winner_lit;
  logic             found;
  logic             slot_free;
  logic             dup;
  logic             load;
  logic             clear;
  logic             flush_act;
  int               idx;

  // First requester at or after ptr, wrapping modulo NUM_ENGINE.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_ENGINE; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_ENGINE) idx = idx - NUM_ENGINE;
      if (!found && eng_req[idx]) begin
        found  = 1'b1;
        winner = SRC_W'(idx);
      end
    end
  end

  assign winner_lit = eng_lit[winner];
  assign slot_free  = !out_valid || out_ready;

`ifdef UC_SCHED_DEDUP_EN
  logic [LIT_W-1:0] last_lit;
  logic             last_vld;

  assign dup = last_vld && (winner_lit == last_lit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_lit <= '0;
      last_vld <= 1'b0;
    end else if (flush_act) begin
      last_vld <= 1'b0;
    end else if (load) begin
      last_lit <= winner_lit;
      last_vld <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // Next-state and grant logic; conflict beats flush beats grant.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    eng_gnt    = '0;
    load       = 1'b0;
    clear      = 1'b0;
    flush_act  = 1'b0;
    if (conflict_in) begin
      state_next = HALT;
      clear      = 1'b1;
    end else if (flush) begin
      state_next = IDLE;
      clear      = 1'b1;
      flush_act  = 1'b1;
      ptr_next   = '0;
    end else if (state != HALT && slot_free) begin
      if (found && rst) begin
        eng_gnt[winner] = 1'b1;
        ptr_next = (winner == SRC_W'(NUM_ENGINE - 1)) ? '0 : winner + 1'b1;
        if (dup) begin
          clear      = 1'b1;
          state_next = IDLE;
        end else begin
          load       = 1'b1;
          state_next = HOLD;
        end
      end else begin
        clear      = 1'b1;
        state_next = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_lit   <= '0;
      out_src   <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_lit   <= winner_lit;
      out_src   <= winner;
    end
  end

  assign busy   = out_valid | (|eng_req);
  assign halted = (state == HALT);

endmodule

// File: tb/tb_uc_rr_sched.sv
// Directed self-checking bench for uc_rr_sched (NUM_ENGINE=4, LIT_W=10).
// Expectations for the duplicate filter follow UC_SCHED_DEDUP_EN.
module tb_uc_rr_sched;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       eng_req;
  logic [3:0][9:0]  eng_lit;
  logic [3:0]       eng_gnt;
  logic             out_valid;
  logic [9:0]       out_lit;
  logic [1:0]       out_src;
  logic             out_ready;
  logic             conflict_in;
  logic             flush;
  logic             busy;
  logic             halted;

  int errors = 0;
  int checks = 0;

  uc_rr_sched #(.NUM_ENGINE(4), .LIT_W(10)) dut (
    .clk(clk), .rst(rst), .eng_req(eng_req), .eng_lit(eng_lit), .eng_gnt(eng_gnt),
    .out_valid(out_valid), .out_lit(out_lit), .out_src(out_src), .out_ready(out_ready),
    .conflict_in(conflict_in), .flush(flush), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; eng_req = '0; eng_lit = '0; out_ready = 1'b0;
    conflict_in = 1'b0; flush = 1'b0;
    #2;
    checks++;
    if ({eng_gnt, out_valid, out_lit, out_src, busy, halted} !== 19'd0) begin
      errors++;
      $display("FAIL reset_values: got gnt=%b v=%b lit=%h src=%0d busy=%b halt=%b, want all zero",
               eng_gnt, out_valid, out_lit, out_src, busy, halted);
    end
    #10 rst = 1'b1;
  endtask

  task automatic test_round_robin();
    tick();
    eng_lit = {10'd8, 10'd7, 10'd6, 10'd5};
    eng_req = 4'b1111; out_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin tick(); #1; end
      checks++;
      if (eng_gnt !== (4'b0001 << k)) begin
        errors++;
        $display("FAIL rr_gnt[%0d]: got %b want %b", k, eng_gnt, 4'b0001 << k);
      end
      if (k > 0) begin
        checks++;
        if ({out_valid, out_lit, out_src} !== {1'b1, 10'(5 + k - 1), 2'(k - 1)}) begin
          errors++;
          $display("FAIL rr_out[%0d]: got v=%b lit=%0d src=%0d want v=1 lit=%0d src=%0d",
                   k, out_valid, out_lit, out_src, 5 + k - 1, k - 1);
        end
      end
    end
    tick(); eng_req = '0; #1;
    checks++;
    if ({eng_gnt, out_valid, out_lit, out_src} !== {4'b0000, 1'b1, 10'd8, 2'd3}) begin
      errors++;
      $display("FAIL rr_last: got gnt=%b v=%b lit=%0d src=%0d want gnt=0000 v=1 lit=8 src=3",
               eng_gnt, out_valid, out_lit, out_src);
    end
    tick(); #1;
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL rr_drain: got v=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_stall();
    eng_lit[2] = 10'd9; eng_req = 4'b0100; out_ready = 1'b0;
    #1;
    checks++;
    if (eng_gnt !== 4'b0100) begin
      errors++;
      $display("FAIL stall_gnt: got %b want 0100", eng_gnt);
    end
    tick(); eng_lit[2] = 10'd11; #1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin tick(); #1; end
      checks++;
      if ({eng_gnt, out_valid, out_lit, out_src} !== {4'b0000, 1'b1, 10'd9, 2'd2}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got gnt=%b v=%b lit=%0d src=%0d want gnt=0000 v=1 lit=9 src=2",
                 c, eng_gnt, out_valid, out_lit, out_src);
      end
    end
    out_ready = 1'b1; #1;
    checks++;
    if (eng_gnt !== 4'b0100) begin
      errors++;
      $display("FAIL stall_release_gnt: got %b want 0100", eng_gnt);
    end
    tick(); eng_req = '0; #1;
    checks++;
    if ({out_valid, out_lit, out_src} !== {1'b1, 10'd11, 2'd2}) begin
      errors++;
      $display("FAIL stall_next: got v=%b lit=%0d src=%0d want v=1 lit=11 src=2",
               out_valid, out_lit, out_src);
    end
    tick(); #1;
  endtask

  task automatic test_wrap();
    eng_lit[3] = 10'd4; eng_req = 4'b1000; #1;
    checks++;
    if (eng_gnt !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_gnt3: got %b want 1000", eng_gnt);
    end
    tick(); eng_req = 4'b1001; eng_lit[0] = 10'd1; #1;
    checks++;
    if ({eng_gnt, out_lit, out_src} !== {4'b0001, 10'd4, 2'd3}) begin
      errors++;
      $display("FAIL wrap_gnt0: got gnt=%b lit=%0d src=%0d want gnt=0001 lit=4 src=3",
               eng_gnt, out_lit, out_src);
    end
    tick(); #1;
    checks++;
    if ({eng_gnt, out_lit, out_src} !== {4'b1000, 10'd1, 2'd0}) begin
      errors++;
      $display("FAIL wrap_ptr1: got gnt=%b lit=%0d src=%0d want gnt=1000 lit=1 src=0",
               eng_gnt, out_lit, out_src);
    end
    tick(); eng_req = '0; #1;
    tick(); #1;
  endtask

  task automatic test_conflict();
    eng_lit = {10'd8, 10'd7, 10'd6, 10'd5};
    eng_req = 4'b1111; out_ready = 1'b0; #1;
    tick(); #1;
    checks++;
    if ({out_valid, out_lit} !== {1'b1, 10'd5}) begin
      errors++;
      $display("FAIL conf_pre: got v=%b lit=%0d want v=1 lit=5", out_valid, out_lit);
    end
    out_ready = 1'b1; conflict_in = 1'b1; #1;
    checks++;
    if (eng_gnt !== 4'b0000) begin
      errors++;
      $display("FAIL conf_gnt: got %b want 0000", eng_gnt);
    end
    tick(); conflict_in = 1'b0; #1;
    checks++;
    if ({eng_gnt, out_valid, halted, busy} !== {4'b0000, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL conf_halt: got gnt=%b v=%b halt=%b busy=%b want gnt=0000 v=0 halt=1 busy=1",
               eng_gnt, out_valid, halted, busy);
    end
    tick(); flush = 1'b1; #1;
    checks++;
    if ({eng_gnt, halted} !== {4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL conf_flush_cycle: got gnt=%b halt=%b want gnt=0000 halt=1", eng_gnt, halted);
    end
    tick(); flush = 1'b0; #1;
    checks++;
    if ({eng_gnt, out_valid, halted} !== {4'b0001, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL conf_restart: got gnt=%b v=%b halt=%b want gnt=0001 v=0 halt=0",
               eng_gnt, out_valid, halted);
    end
    tick(); eng_req = '0; #1;
    checks++;
    if ({out_valid, out_lit, out_src} !== {1'b1, 10'd5, 2'd0}) begin
      errors++;
      $display("FAIL conf_first: got v=%b lit=%0d src=%0d want v=1 lit=5 src=0",
               out_valid, out_lit, out_src);
    end
    tick(); #1;
  endtask

  task automatic test_dedup();
    flush = 1'b1; #1;
    tick(); flush = 1'b0;
    eng_lit = {4{10'h3FD}}; eng_req = 4'b0011; out_ready = 1'b1; #1;
    checks++;
    if (eng_gnt !== 4'b0001) begin
      errors++;
      $display("FAIL dedup_gnt0: got %b want 0001", eng_gnt);
    end
    tick(); eng_req = 4'b0010; #1;
    checks++;
    if ({eng_gnt, out_valid, out_lit, out_src} !== {4'b0010, 1'b1, 10'h3FD, 2'd0}) begin
      errors++;
      $display("FAIL dedup_first: got gnt=%b v=%b lit=%h src=%0d want gnt=0010 v=1 lit=3fd src=0",
               eng_gnt, out_valid, out_lit, out_src);
    end
    tick(); eng_req = '0; #1;
`ifdef UC_SCHED_DEDUP_EN
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL dedup_second: got v=%b want v=0 (duplicate dropped)", out_valid);
    end
`else
    checks++;
    if ({out_valid, out_lit, out_src} !== {1'b1, 10'h3FD, 2'd1}) begin
      errors++;
      $display("FAIL dedup_second: got v=%b lit=%h src=%0d want v=1 lit=3fd src=1",
               out_valid, out_lit, out_src);
    end
`endif
    tick(); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL dedup_drain: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    eng_lit[2] = 10'd2; eng_req = 4'b0100; out_ready = 1'b0; #1;
    tick(); #1;
    checks++;
    if ({out_valid, out_lit, out_src} !== {1'b1, 10'd2, 2'd2}) begin
      errors++;
      $display("FAIL areset_pre: got v=%b lit=%0d src=%0d want v=1 lit=2 src=2",
               out_valid, out_lit, out_src);
    end
    rst = 1'b0; #1;
    checks++;
    if ({eng_gnt, out_valid, out_lit, out_src, halted} !== 18'd0) begin
      errors++;
      $display("FAIL areset_values: got gnt=%b v=%b lit=%h src=%0d halt=%b want all zero",
               eng_gnt, out_valid, out_lit, out_src, halted);
    end
    eng_req = '0; #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL areset_busy: got %b want 0", busy);
    end
    rst = 1'b1;
    eng_req = 4'b0001; eng_lit[0] = 10'd3; #1;
    checks++;
    if (eng_gnt !== 4'b0001) begin
      errors++;
      $display("FAIL areset_restart: got %b want 0001 (ptr back to 0)", eng_gnt);
    end
    tick(); eng_req = '0; #1;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_wrap();
    test_conflict();
    test_dedup();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
